// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit.
package mdu_pkg;

  // Width of the iteration counter; wide enough for ITER up to 63.
  localparam int unsigned CNT_W = 6;

  // Operation encodings carried on the op port.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } mdu_state_e;

  // MULT and DIV treat operands as two's complement; the others as unsigned.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Divides have op[1] set.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Turns magnitude results from the iterative datapath into signed HI/LO values.
module mdu_sign_fix #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic            neg_a_i,
  input  logic            neg_b_i,
  input  logic            div_zero_i,
  input  logic [XLEN-1:0] mag_hi_i,
  input  logic [XLEN-1:0] mag_lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [2*XLEN-1:0] prod;

  // Negate the product, or the quotient/remainder individually, as the signs demand.
  always_comb begin
    prod = {mag_hi_i, mag_lo_i};
    hi_o = mag_hi_i;
    lo_o = mag_lo_i;
    if (is_div_i) begin
      // Remainder follows the dividend; quotient follows the sign product.
      hi_o = neg_a_i ? (~mag_hi_i + 1'b1) : mag_hi_i;
      lo_o = (neg_a_i ^ neg_b_i) ? (~mag_lo_i + 1'b1) : mag_lo_i;
      // A zero divisor yields an all-ones quotient; remainder is already the dividend.
      if (div_zero_i) begin
        lo_o = '1;
      end
    end else begin
      if (neg_a_i ^ neg_b_i) begin
        prod = ~prod + 1'b1;
      end
      hi_o = prod[2*XLEN-1:XLEN];
      lo_o = prod[XLEN-1:0];
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [XLEN-1:0]  mag_b_q, mag_b_d;
  // Upper partial: product high half / running remainder (one guard bit).
  logic [XLEN:0]    acc_hi_q, acc_hi_d;
  // Lower partial: multiplier being shifted out / quotient being shifted in.
  logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;

  logic            in_signed;
  logic            in_neg_a;
  logic            in_neg_b;
  logic [XLEN-1:0] mul_add;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN:0]   step_hi;
  logic [XLEN-1:0] step_lo;
  logic [XLEN-1:0] fix_hi;
  logic [XLEN-1:0] fix_lo;

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    mul_add   = acc_lo_q[0] ? mag_b_q : '0;
    mul_sum   = acc_hi_q + {1'b0, mul_add};
    div_shift = {acc_hi_q[XLEN-1:0], acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (op_is_div(op_q)) begin
      // Top bit of the difference set means the trial subtraction went negative.
      if (!div_diff[XLEN]) begin
        step_hi = div_diff;
        step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift;
        step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = {1'b0, mul_sum[XLEN:1]};
      step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  mdu_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .is_div_i  (op_is_div(op_q)),
    .neg_a_i   (neg_a_q),
    .neg_b_i   (neg_b_q),
    .div_zero_i(mag_b_q == '0),
    .mag_hi_i  (acc_hi_q[XLEN-1:0]),
    .mag_lo_i  (acc_lo_q),
    .hi_o      (fix_hi),
    .lo_o      (fix_lo)
  );

  // Next-state logic for the IDLE/CALC/FIN sequencer and all registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mag_b_d  = mag_b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    in_signed = op_is_signed(op);
    in_neg_a  = in_signed & a[XLEN-1];
    in_neg_b  = in_signed & b[XLEN-1];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // start has priority; a coincident mthi/mtlo is dropped.
          op_d     = op;
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          mag_b_d  = in_neg_b ? (~b + 1'b1) : b;
          acc_hi_d = '0;
          acc_lo_d = in_neg_a ? (~a + 1'b1) : a;
          cnt_d    = CNT_W'(ITER);
          busy_d   = 1'b1;
          state_d  = StCalc;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      StCalc: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_b_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_b_q  <= mag_b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
